// File: rtl/dmem_port_arbiter.sv
// Two-requester (cpu / loader) arbiter for the single data-memory port.
// Checks alignment, sequences req/ack, and waits out the memory read latency.
module dmem_port_arbiter #(
   parameter int READ_LAT     = 1,
   parameter int PRIORITY_CPU = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic        cpu_err,
   input  logic        ldr_req,
   input  logic        ldr_we,
   input  logic [1:0]  ldr_size,
   input  logic [31:0] ldr_addr,
   input  logic [31:0] ldr_wdata,
   output logic        ldr_ack,
   output logic        ldr_err,
   output logic [31:0] rdata_out,
   output logic        mem_re,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // state | meaning
   // IDLE  | no access in flight; arbitrate and latch the winner
   // ISSUE | one-cycle mem_re/mem_we pulse for the granted access
   // WAIT  | counting down read latency; capture mem_rdata on the last cycle
   // DONE  | one-cycle ack (and err) to the owner

   localparam int          SW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [2:0]  WAIT_INIT = 3'(READ_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            last_ldr_q;
   logic            owner_q;
   logic            we_q;
   logic            err_q;
   logic [2:0]      wait_q;
   logic [31:0]     rdata_q;
   logic [1:0]      mem_size_q;
   logic [31:0]     mem_addr_q;
   logic [31:0]     mem_wdata_q;

   logic            any_req;
   logic            both_req;
   logic            pick_ldr;
   logic            sel_we;
   logic [1:0]      sel_size;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;
   logic            sel_bad;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         2'b11:   return (a != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      any_req  = cpu_req | ldr_req;
      both_req = cpu_req & ldr_req;
      if (both_req) begin
         if (PRIORITY_CPU != 0) pick_ldr = (starve_q == SW'(STARVE_LIMIT));
         else                   pick_ldr = ~last_ldr_q;
      end else begin
         pick_ldr = ldr_req;
      end
      sel_we    = pick_ldr ? ldr_we    : cpu_we;
      sel_size  = pick_ldr ? ldr_size  : cpu_size;
      sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
      sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
      sel_bad   = misaligned(sel_size, sel_addr[1:0]);
   end

   // Starvation counter only moves while arbitrating; any ldr grant or idle ldr clears it.
   always_comb begin
      starve_d = starve_q;
      if (state_q == S_IDLE) begin
         if (!ldr_req || (any_req && pick_ldr)) starve_d = '0;
         else if (both_req && (PRIORITY_CPU != 0)) starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_req) state_d = sel_bad ? S_DONE : S_ISSUE;
         S_ISSUE: state_d = we_q ? S_DONE : S_WAIT;
         S_WAIT:  if (wait_q == 3'd0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_re  = (state_q == S_ISSUE) & ~we_q;
      mem_we  = (state_q == S_ISSUE) &  we_q;
      cpu_ack = (state_q == S_DONE) & ~owner_q;
      cpu_err = (state_q == S_DONE) & ~owner_q & err_q;
      ldr_ack = (state_q == S_DONE) &  owner_q;
      ldr_err = (state_q == S_DONE) &  owner_q & err_q;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         starve_q    <= '0;
         last_ldr_q  <= 1'b1;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         wait_q      <= 3'd0;
         rdata_q     <= 32'h0;
         mem_size_q  <= 2'b00;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         starve_q <= starve_d;
         if (state_q == S_IDLE && any_req) begin
            owner_q    <= pick_ldr;
            we_q       <= sel_we;
            err_q      <= sel_bad;
            last_ldr_q <= pick_ldr;
            // Rejected accesses never touch the memory-side buses.
            if (!sel_bad) begin
               mem_size_q  <= sel_size;
               mem_addr_q  <= sel_addr;
               mem_wdata_q <= sel_wdata;
            end
         end
         if (state_q == S_ISSUE) begin
            wait_q <= WAIT_INIT;
         end else if (state_q == S_WAIT && wait_q != 3'd0) begin
            wait_q <= wait_q - 3'd1;
         end
         if (state_q == S_WAIT && wait_q == 3'd0) rdata_q <= mem_rdata;
      end
   end

   assign rdata_out = rdata_q;
   assign mem_size  = mem_size_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: one cpu-priority instance (a_*)
// and one alternating-tie instance (b_*) share all inputs.
module tb_dmem_port_arbiter;
   localparam int RL = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [1:0]  cpu_size = 2'b00;
   logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
   logic        ldr_req = 1'b0, ldr_we = 1'b0;
   logic [1:0]  ldr_size = 2'b00;
   logic [31:0] ldr_addr = 32'h0, ldr_wdata = 32'h0;
   logic [31:0] mem_rdata = 32'h0BAD_F00D;

   logic        a_cpu_ack, a_cpu_err, a_ldr_ack, a_ldr_err, a_mem_re, a_mem_we;
   logic [1:0]  a_mem_size;
   logic [31:0] a_rdata_out, a_mem_addr, a_mem_wdata;
   logic        b_cpu_ack, b_cpu_err, b_ldr_ack, b_ldr_err, b_mem_re, b_mem_we;
   logic [1:0]  b_mem_size;
   logic [31:0] b_rdata_out, b_mem_addr, b_mem_wdata;

   dmem_port_arbiter #(.READ_LAT(RL), .PRIORITY_CPU(1), .STARVE_LIMIT(4)) u_dut_a (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(a_cpu_ack), .cpu_err(a_cpu_err),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_size(ldr_size), .ldr_addr(ldr_addr),
      .ldr_wdata(ldr_wdata), .ldr_ack(a_ldr_ack), .ldr_err(a_ldr_err),
      .rdata_out(a_rdata_out), .mem_re(a_mem_re), .mem_we(a_mem_we),
      .mem_size(a_mem_size), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(mem_rdata));

   dmem_port_arbiter #(.READ_LAT(RL), .PRIORITY_CPU(0), .STARVE_LIMIT(4)) u_dut_b (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(b_cpu_ack), .cpu_err(b_cpu_err),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_size(ldr_size), .ldr_addr(ldr_addr),
      .ldr_wdata(ldr_wdata), .ldr_ack(b_ldr_ack), .ldr_err(b_ldr_err),
      .rdata_out(b_rdata_out), .mem_re(b_mem_re), .mem_we(b_mem_we),
      .mem_size(b_mem_size), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(mem_rdata));

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic        own;
      logic        err;
      logic [31:0] rd;
      int          lat;
      logic [31:0] addr;
   } exp_t;
   exp_t sb[$];

   // Memory model: data valid exactly RL cycles after the mem_re cycle, junk otherwise.
   logic [7:0]  re_hist = 8'h0;
   logic [31:0] mm [bit [31:0]];
   always @(negedge clock) begin
      if (a_mem_we === 1'b1) mm[a_mem_addr] = a_mem_wdata;
      re_hist = {re_hist[6:0], (a_mem_re === 1'b1)};
      if (re_hist[RL])
         mem_rdata = mm.exists(a_mem_addr) ? mm[a_mem_addr] : (a_mem_addr ^ 32'hA5A5_A5A5);
      else
         mem_rdata = 32'h0BAD_F00D;
   end

   function automatic exp_t mk_exp(input logic own, input logic err, input logic [31:0] rd,
                                   input int lat, input logic [31:0] addr);
      exp_t e;
      e.own = own; e.err = err; e.rd = rd; e.lat = lat; e.addr = addr;
      return e;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drop_reqs();
      cpu_req = 1'b0;
      ldr_req = 1'b0;
   endtask

   // Steps until the selected instance acks; reports what was seen, compares nothing.
   task automatic observe(input bit use_b, input int budget, input int drop_at,
                          output int lat, output logic own, output logic err, output logic oth,
                          output logic [31:0] rd, output int we_at, output int re_at,
                          output logic [31:0] addr_at);
      logic ca, ce, la, le, mre, mwe;
      lat = -1; own = 1'b0; err = 1'b0; oth = 1'b0; rd = 32'h0;
      we_at = 0; re_at = 0; addr_at = 32'h0;
      for (int k = 1; k <= budget; k++) begin
         step();
         if (k == drop_at) drop_reqs();
         ca  = use_b ? b_cpu_ack : a_cpu_ack;
         ce  = use_b ? b_cpu_err : a_cpu_err;
         la  = use_b ? b_ldr_ack : a_ldr_ack;
         le  = use_b ? b_ldr_err : a_ldr_err;
         mre = use_b ? b_mem_re  : a_mem_re;
         mwe = use_b ? b_mem_we  : a_mem_we;
         if (mwe === 1'b1 && we_at == 0) begin
            we_at   = k;
            addr_at = use_b ? b_mem_addr : a_mem_addr;
         end
         if (mre === 1'b1 && re_at == 0) begin
            re_at   = k;
            addr_at = use_b ? b_mem_addr : a_mem_addr;
         end
         if (ca === 1'b1 || la === 1'b1) begin
            lat = k;
            own = la;
            err = la ? le : ce;
            oth = la ? (ca | ce) : le;
            rd  = use_b ? b_rdata_out : a_rdata_out;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drop_reqs();
      step(); step();
      n_assert++;
      if ({a_cpu_ack, a_cpu_err, a_ldr_ack, a_ldr_err, a_mem_re, a_mem_we} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {a_cpu_ack, a_cpu_err, a_ldr_ack, a_ldr_err, a_mem_re, a_mem_we});
      end
      n_assert++;
      if ({a_rdata_out, a_mem_size, a_mem_addr, a_mem_wdata} !== 98'b0) begin
         n_fail++;
         $display("FAIL reset_bus: rdata=%h size=%b addr=%h wdata=%h expected all 0",
                  a_rdata_out, a_mem_size, a_mem_addr, a_mem_wdata);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_store();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      cpu_we = 1'b1; cpu_size = 2'b11; cpu_addr = 32'h1000_0010; cpu_wdata = 32'hDEAD_BEEF;
      cpu_req = 1'b1;
      sb.push_back(mk_exp(1'b0, 1'b0, 32'h0, 2, 32'h1000_0010));
      observe(1'b0, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
      drop_reqs(); step();
      e = sb.pop_front();
      n_assert++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL store_lat: got %0d expected %0d", lat, e.lat); end
      n_assert++;
      if ({own, err, oth} !== {e.own, e.err, 1'b0}) begin
         n_fail++; $display("FAIL store_ack: got own/err/oth=%b expected %b", {own, err, oth}, {e.own, e.err, 1'b0});
      end
      n_assert++;
      if (we_at !== 1 || re_at !== 0) begin
         n_fail++; $display("FAIL store_en: we_at=%0d re_at=%0d expected 1 and 0", we_at, re_at);
      end
      n_assert++;
      if (addr_at !== e.addr || a_mem_wdata !== 32'hDEAD_BEEF || a_mem_size !== 2'b11) begin
         n_fail++; $display("FAIL store_bus: addr=%h wdata=%h size=%b expected %h DEADBEEF 11",
                            addr_at, a_mem_wdata, a_mem_size, e.addr);
      end
   endtask

   task automatic test_load();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      cpu_we = 1'b0; cpu_size = 2'b11; cpu_addr = 32'h1000_0010; cpu_req = 1'b1;
      sb.push_back(mk_exp(1'b0, 1'b0, 32'hDEAD_BEEF, 2 + RL, 32'h1000_0010));
      observe(1'b0, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
      drop_reqs(); step();
      e = sb.pop_front();
      n_assert++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL load_lat: got %0d expected %0d", lat, e.lat); end
      n_assert++;
      if ({own, err, oth} !== {e.own, e.err, 1'b0}) begin
         n_fail++; $display("FAIL load_ack: got own/err/oth=%b expected %b", {own, err, oth}, {e.own, e.err, 1'b0});
      end
      n_assert++;
      if (re_at !== 1 || we_at !== 0 || addr_at !== e.addr) begin
         n_fail++; $display("FAIL load_en: re_at=%0d we_at=%0d addr=%h expected 1 0 %h", re_at, we_at, addr_at, e.addr);
      end
      n_assert++;
      if (rd !== e.rd) begin n_fail++; $display("FAIL load_data: got %h expected %h", rd, e.rd); end
      n_assert++;
      if (a_rdata_out !== e.rd) begin n_fail++; $display("FAIL load_hold: got %h expected %h", a_rdata_out, e.rd); end
   endtask

   task automatic test_misaligned();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      logic who;
      for (int i = 0; i < 4; i++) begin
         who = (i == 3);
         case (i)
            0: begin cpu_size = 2'b01; cpu_addr = 32'h1000_0003; end
            1: begin cpu_size = 2'b11; cpu_addr = 32'h1000_0002; end
            2: begin cpu_size = 2'b10; cpu_addr = 32'h1000_0000; end
            default: begin ldr_size = 2'b11; ldr_addr = 32'h2000_0001; end
         endcase
         cpu_we = 1'b0; ldr_we = 1'b1;
         cpu_req = ~who; ldr_req = who;
         sb.push_back(mk_exp(who, 1'b1, 32'hDEAD_BEEF, 1, 32'h1000_0010));
         observe(1'b0, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
         drop_reqs(); step();
         e = sb.pop_front();
         n_assert++;
         if (lat !== e.lat) begin n_fail++; $display("FAIL mis%0d_lat: got %0d expected %0d", i, lat, e.lat); end
         n_assert++;
         if ({own, err, oth} !== {e.own, e.err, 1'b0}) begin
            n_fail++; $display("FAIL mis%0d_ack: got own/err/oth=%b expected %b", i, {own, err, oth}, {e.own, e.err, 1'b0});
         end
         n_assert++;
         if (we_at !== 0 || re_at !== 0) begin
            n_fail++; $display("FAIL mis%0d_en: we_at=%0d re_at=%0d expected none", i, we_at, re_at);
         end
         n_assert++;
         if (rd !== e.rd || a_mem_addr !== e.addr) begin
            n_fail++; $display("FAIL mis%0d_hold: rdata=%h addr=%h expected %h %h", i, rd, a_mem_addr, e.rd, e.addr);
         end
      end
   endtask

   task automatic test_ldr_load();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      ldr_we = 1'b0; ldr_size = 2'b00; ldr_addr = 32'h2000_0007; ldr_req = 1'b1;
      sb.push_back(mk_exp(1'b1, 1'b0, 32'h85A5_A5A2, 2 + RL, 32'h2000_0007));
      observe(1'b0, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
      drop_reqs(); step();
      e = sb.pop_front();
      n_assert++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL ldr_lat: got %0d expected %0d", lat, e.lat); end
      n_assert++;
      if ({own, err, oth} !== {e.own, e.err, 1'b0}) begin
         n_fail++; $display("FAIL ldr_ack: got own/err/oth=%b expected %b", {own, err, oth}, {e.own, e.err, 1'b0});
      end
      n_assert++;
      if (rd !== e.rd || addr_at !== e.addr || a_mem_size !== 2'b00) begin
         n_fail++; $display("FAIL ldr_data: rdata=%h addr=%h size=%b expected %h %h 00", rd, addr_at, a_mem_size, e.rd, e.addr);
      end
   endtask

   task automatic test_drop();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      cpu_we = 1'b1; cpu_size = 2'b11; cpu_addr = 32'h0000_0300; cpu_wdata = 32'h1234_5678;
      cpu_req = 1'b1;
      sb.push_back(mk_exp(1'b0, 1'b0, 32'h0, 2, 32'h0000_0300));
      observe(1'b0, 20, 1, lat, own, err, oth, rd, we_at, re_at, addr_at);
      drop_reqs(); step();
      e = sb.pop_front();
      n_assert++;
      if (lat !== e.lat || own !== e.own || err !== e.err) begin
         n_fail++; $display("FAIL drop_ack: lat=%0d own=%b err=%b expected %0d %b %b", lat, own, err, e.lat, e.own, e.err);
      end
      n_assert++;
      if (we_at !== 1 || addr_at !== e.addr) begin
         n_fail++; $display("FAIL drop_en: we_at=%0d addr=%h expected 1 %h", we_at, addr_at, e.addr);
      end
   endtask

   task automatic test_priority();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      cpu_we = 1'b1; cpu_size = 2'b11; cpu_addr = 32'h0000_0100; cpu_wdata = 32'h1111_1111;
      ldr_we = 1'b1; ldr_size = 2'b11; ldr_addr = 32'h0000_0200; ldr_wdata = 32'h2222_2222;
      cpu_req = 1'b1; ldr_req = 1'b1;
      for (int g = 0; g < 10; g++)
         sb.push_back(mk_exp((g % 5) == 4, 1'b0, 32'h0, 0, ((g % 5) == 4) ? 32'h0000_0200 : 32'h0000_0100));
      for (int g = 0; g < 10; g++) begin
         observe(1'b0, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
         e = sb.pop_front();
         n_assert++;
         if (lat < 0 || {own, err, oth} !== {e.own, e.err, 1'b0} || addr_at !== e.addr) begin
            n_fail++; $display("FAIL prio_grant%0d: lat=%0d own/err/oth=%b addr=%h expected own=%b addr=%h",
                               g, lat, {own, err, oth}, addr_at, e.own, e.addr);
         end
      end
      drop_reqs(); step();
   endtask

   task automatic test_alternate();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      reset = 1'b0; step(); reset = 1'b1;
      cpu_req = 1'b1; ldr_req = 1'b1;
      for (int g = 0; g < 6; g++)
         sb.push_back(mk_exp((g % 2) == 1, 1'b0, 32'h0, 0, ((g % 2) == 1) ? 32'h0000_0200 : 32'h0000_0100));
      for (int g = 0; g < 6; g++) begin
         observe(1'b1, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
         e = sb.pop_front();
         n_assert++;
         if (lat < 0 || {own, err, oth} !== {e.own, e.err, 1'b0} || addr_at !== e.addr) begin
            n_fail++; $display("FAIL alt_grant%0d: lat=%0d own/err/oth=%b addr=%h expected own=%b addr=%h",
                               g, lat, {own, err, oth}, addr_at, e.own, e.addr);
         end
      end
      drop_reqs();
      for (int k = 0; k < 8; k++) step();
   endtask

   task automatic test_reset_wait();
      int lat, we_at, re_at; logic own, err, oth; logic [31:0] rd, addr_at; exp_t e;
      logic saw_ack;
      cpu_we = 1'b0; cpu_size = 2'b11; cpu_addr = 32'h1000_0010; cpu_req = 1'b1;
      sb.push_back(mk_exp(1'b0, 1'b0, 32'hDEAD_BEEF, 2 + RL, 32'h1000_0010));
      observe(1'b0, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
      drop_reqs(); step();
      e = sb.pop_front();
      n_assert++;
      if (lat !== e.lat || rd !== e.rd) begin
         n_fail++; $display("FAIL rw_preload: lat=%0d rdata=%h expected %0d %h", lat, rd, e.lat, e.rd);
      end
      ldr_we = 1'b0; ldr_size = 2'b11; ldr_addr = 32'h1000_0010; ldr_req = 1'b1;
      step();
      n_assert++;
      if (a_mem_re !== 1'b1) begin n_fail++; $display("FAIL rw_issue: mem_re=%b expected 1", a_mem_re); end
      step();
      reset = 1'b0;
      step();
      n_assert++;
      if ({a_ldr_ack, a_ldr_err, a_cpu_ack, a_mem_re} !== 4'b0 || a_rdata_out !== 32'h0 || a_mem_addr !== 32'h0) begin
         n_fail++; $display("FAIL rw_reset: acks/re=%b rdata=%h addr=%h expected 0 0 0",
                            {a_ldr_ack, a_ldr_err, a_cpu_ack, a_mem_re}, a_rdata_out, a_mem_addr);
      end
      reset = 1'b1; ldr_req = 1'b0;
      saw_ack = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (a_ldr_ack !== 1'b0 || a_cpu_ack !== 1'b0) saw_ack = 1'b1;
      end
      n_assert++;
      if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL rw_no_ack: saw ack=%b expected 0", saw_ack); end
      cpu_we = 1'b1; cpu_size = 2'b11; cpu_addr = 32'h0000_0400; cpu_wdata = 32'hCAFE_0001; cpu_req = 1'b1;
      sb.push_back(mk_exp(1'b0, 1'b0, 32'h0, 2, 32'h0000_0400));
      observe(1'b0, 20, 0, lat, own, err, oth, rd, we_at, re_at, addr_at);
      drop_reqs(); step();
      e = sb.pop_front();
      n_assert++;
      if (lat !== e.lat || {own, err, oth} !== {e.own, e.err, 1'b0} || addr_at !== e.addr) begin
         n_fail++; $display("FAIL rw_after: lat=%0d own/err/oth=%b addr=%h expected %0d %b %h",
                            lat, {own, err, oth}, addr_at, e.lat, {e.own, e.err, 1'b0}, e.addr);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_misaligned();
      test_ldr_load();
      test_drop();
      test_priority();
      test_alternate();
      test_reset_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
